ipml_fifo_rr_drain_arb: RTL and testbench

Round-robin burst arbiter that drains N prefetch FIFOs (first-word-fall-through read side: vld/data/rd_en, pop = vld & rd_en) into one shared downstream stream. It sits between several per-channel prefetch FIFOs and a single consumer, such as an audio DMA or packetiser. Each grant lasts up to BURST_LEN beats, then priority rotates. A per-source enable mask lets software take channels out of service.

---
 rtl/ipml_fifo_rr_drain_arb.sv | 128 ++++++++++++
 tb/tb_ipml_fifo_rr_drain_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_fifo_rr_drain_arb.sv
`timescale 1ns/1ps
// Round-robin burst arbiter draining N first-word-fall-through prefetch FIFOs
// into one shared stream, with a per-source enable mask and bounded bursts.
module ipml_fifo_rr_drain_arb #(
    parameter int N_SRC     = 4,
    parameter int W         = 32,
    parameter int BURST_LEN = 16,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     src_vld,
    input  logic [N_SRC*W-1:0]   src_data,
    output logic [N_SRC-1:0]     src_rd_en,
    input  logic [N_SRC-1:0]     src_mask,
    output logic [W-1:0]         out_data,
    output logic                 out_vld,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_src,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [N_SRC-1:0] req;
    logic             found;
    logic [SEL_W-1:0] pick;
    logic [SEL_W:0]   cand;
    logic [SEL_W-1:0] next_ptr;
    logic             in_grant;
    logic             eff;
    logic             xfer;
    logic             cnt_max;

    // Rotating search: first eligible source at or after rr_ptr, wrapping at N_SRC.
    always_comb begin
        req   = src_vld & src_mask;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(N_SRC)) begin
                cand = cand - (SEL_W+1)'(N_SRC);
            end
            if (!found && req[cand[SEL_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[SEL_W-1:0];
            end
        end
    end

    assign in_grant = (state_q == GRANT);
    assign eff      = in_grant & src_vld[grant_q] & src_mask[grant_q];
    assign xfer     = eff & out_ready;
    assign cnt_max  = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
    assign next_ptr = (grant_q == SEL_W'(N_SRC - 1)) ? '0 : grant_q + SEL_W'(1);

    always_comb begin
        out_vld   = eff;
        out_data  = '0;
        out_src   = '0;
        out_last  = xfer & cnt_max;
        busy      = in_grant;
        src_rd_en = '0;
        if (in_grant) begin
            out_data = src_data[grant_q*W +: W];
            out_src  = grant_q;
        end
        if (xfer) begin
            src_rd_en[grant_q] = 1'b1;
        end
    end

    // A stalled consumer holds everything; a dry or masked source ends the burst early.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    grant_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!eff) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (xfer) begin
                    if (cnt_max) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ipml_fifo_rr_drain_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for ipml_fifo_rr_drain_arb: queue-based FIFO sources, an
// arbitration reference model, and a monitor comparing every accepted beat.
module tb_ipml_fifo_rr_drain_arb;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int B     = 16;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     src_vld;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_rd_en;
    logic [N-1:0]     src_mask;
    logic [W-1:0]     out_data;
    logic             out_vld;
    logic             out_ready;
    logic [SEL_W-1:0] out_src;
    logic             out_last;
    logic             busy;

    always #5 clk = ~clk;

    ipml_fifo_rr_drain_arb #(
        .N_SRC(N), .W(W), .BURST_LEN(B), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_vld(src_vld), .src_data(src_data), .src_rd_en(src_rd_en),
        .src_mask(src_mask),
        .out_data(out_data), .out_vld(out_vld), .out_ready(out_ready),
        .out_src(out_src), .out_last(out_last), .busy(busy)
    );

    typedef struct packed {
        logic [SEL_W-1:0] src;
        logic [W-1:0]     data;
        logic             last;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    logic [W-1:0] fifoQ [N][$];
    int          seqNum [N];
    beat_t       sbQ [$];

    bit mBusy;
    int mGrant;
    int mPtr;
    int mCnt;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushWords(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            fifoQ[s].push_back({8'(s), 24'(seqNum[s])});
            seqNum[s]++;
        end
    endtask

    function automatic bit allEmpty();
        for (int i = 0; i < N; i++) if (fifoQ[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            src_vld[i] = (fifoQ[i].size() != 0);
            src_data[i*W +: W] = (fifoQ[i].size() != 0) ? fifoQ[i][0] : W'($urandom);
        end
    endtask

    task automatic resetModel();
        mBusy = 1'b0; mGrant = 0; mPtr = 0; mCnt = 0;
        for (int i = 0; i < N; i++) fifoQ[i].delete();
        sbQ.delete();
    endtask

    // One clock cycle: drive, predict, compare, then advance FIFOs and model.
    task automatic applyStimulus(input bit rdy, input logic [N-1:0] mask);
        logic [N-1:0] expRdEn;
        logic [N-1:0] seenRdEn;
        bit expVld, expLast, eff, nBusy;
        int nGrant, nPtr, nCnt, idx;
        beat_t b;
        @(negedge clk);
        out_ready = rdy;
        src_mask  = mask;
        driveInputs();
        #1;
        expRdEn = '0; expVld = 1'b0; expLast = 1'b0;
        nBusy = mBusy; nGrant = mGrant; nPtr = mPtr; nCnt = mCnt;
        if (!mBusy) begin
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (!nBusy && fifoQ[idx].size() != 0 && mask[idx]) begin
                    nBusy = 1'b1; nGrant = idx; nCnt = 0;
                end
            end
        end else begin
            eff    = (fifoQ[mGrant].size() != 0) && mask[mGrant];
            expVld = eff;
            if (!eff) begin
                nBusy = 1'b0; nPtr = (mGrant + 1) % N;
            end else if (rdy) begin
                expRdEn[mGrant] = 1'b1;
                expLast = (mCnt == B - 1);
                b.src = SEL_W'(mGrant); b.data = fifoQ[mGrant][0]; b.last = expLast;
                sbQ.push_back(b);
                if (expLast) begin
                    nBusy = 1'b0; nPtr = (mGrant + 1) % N;
                end else begin
                    nCnt = mCnt + 1;
                end
            end
            checkOutput("out_src", 64'(out_src), 64'(mGrant));
        end
        checkOutput("busy", 64'(busy), 64'(mBusy));
        checkOutput("out_vld", 64'(out_vld), 64'(expVld));
        checkOutput("src_rd_en", 64'(src_rd_en), 64'(expRdEn));
        checkOutput("out_last", 64'(out_last), 64'(expLast));
        seenRdEn = src_rd_en;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (seenRdEn[i] && fifoQ[i].size() != 0) void'(fifoQ[i].pop_front());
        end
        mBusy = nBusy; mGrant = nGrant; mPtr = nPtr; mCnt = nCnt;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((!allEmpty() || mBusy) && n < budget) begin
            applyStimulus(1'b1, 4'hF);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 64'(n), 64'(0));
    endtask

    // Monitor: every accepted beat must match the oldest predicted beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_vld && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(out_data), 64'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("beat_data", 64'(out_data), 64'(e.data));
                    checkOutput("beat_src", 64'(out_src), 64'(e.src));
                    checkOutput("beat_last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; out_ready = 1'b0; src_mask = '0; src_vld = '0; src_data = '0;
        for (int i = 0; i < N; i++) seqNum[i] = 0;
        resetModel();
        repeat (2) @(negedge clk);
        src_mask = 4'hF; out_ready = 1'b1;
        #1;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_out_vld", 64'(out_vld), 64'(0));
        checkOutput("reset_rd_en", 64'(src_rd_en), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single source, one full burst then a short one
        pushWords(0, 20);
        drain(60);

        // All sources saturated: strict rotation, one bubble between bursts
        for (int i = 0; i < N; i++) pushWords(i, 32);
        drain(200);

        // Consumer stalls with ready pattern 1,0,0,1
        pushWords(2, 6);
        for (int c = 0; c < 24; c++) applyStimulus((c % 4 == 0) || (c % 4 == 3), 4'hF);
        drain(40);

        // Mask drop mid-burst on source 1 while source 2 waits
        pushWords(1, 12); pushWords(2, 4);
        while (!(mBusy && mGrant == 1 && mCnt == 5)) applyStimulus(1'b1, 4'hF);
        for (int c = 0; c < 12; c++) applyStimulus(1'b1, 4'hD);
        drain(40);

        // Pointer wrap: leave rr_ptr at 3, then only source 0 requests
        pushWords(2, 3);
        drain(20);
        pushWords(0, 5);
        drain(20);

        // Randomized traffic, masks and backpressure
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) begin
                n = $urandom_range(N - 1);
                if (fifoQ[n].size() < 40) pushWords(n, $urandom_range(8, 1));
            end
            applyStimulus($urandom_range(3) != 0,
                          {($urandom_range(15) != 0), ($urandom_range(15) != 0),
                           ($urandom_range(15) != 0), ($urandom_range(15) != 0)});
        end
        drain(400);

        // Reset at beat 7 of a burst
        pushWords(0, 20);
        n = 0;
        while (!(mBusy && mCnt == 7) && n < 40) begin
            applyStimulus(1'b1, 4'hF);
            n++;
        end
        @(negedge clk);
        out_ready = 1'b1; src_mask = 4'hF;
        driveInputs();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_out_vld", 64'(out_vld), 64'(0));
        checkOutput("midrst_rd_en", 64'(src_rd_en), 64'(0));
        checkOutput("midrst_out_last", 64'(out_last), 64'(0));
        resetModel();
        @(negedge clk);
        driveInputs();
        rst_n = 1'b1;
        pushWords(1, 4); pushWords(3, 4);
        drain(40);

        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
